// File: rtl/uart_register_block_if.sv
// Register bus plus UART TX/RX byte handshakes for uart_register_block.
// master = APB/UART-PHY side, slave = the register block.
interface uart_register_block_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              reg_wr_en;
    logic              reg_rd_en;
    logic [ADDR_W-1:0] reg_address;
    logic [DATA_W-1:0] data_write_to_reg;
    logic              start_tx;
    logic [DATA_W-1:0] reg_rd_data;
    logic [DATA_W-1:0] rx_data_in;
    logic              tx_done_signal;
    logic              rx_done_signal;
    logic              parity_error_signal;
    logic [DATA_W-1:0] tx_byte;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_complete;
    logic [DATA_W-1:0] rx_byte;
    logic              rx_valid;
    logic              rx_parity_err;
    logic [DATA_W-1:0] cfg_out;

    modport master (
        output reg_wr_en, reg_rd_en, reg_address, data_write_to_reg, start_tx,
               tx_ready, tx_complete, rx_byte, rx_valid, rx_parity_err,
        input  reg_rd_data, rx_data_in, tx_done_signal, rx_done_signal,
               parity_error_signal, tx_byte, tx_valid, cfg_out
    );

    modport slave (
        input  reg_wr_en, reg_rd_en, reg_address, data_write_to_reg, start_tx,
               tx_ready, tx_complete, rx_byte, rx_valid, rx_parity_err,
        output reg_rd_data, rx_data_in, tx_done_signal, rx_done_signal,
               parity_error_signal, tx_byte, tx_valid, cfg_out
    );
endinterface

// File: rtl/uart_register_block.sv
// UART register block: TX_DATA/RX_DATA/CFG/CTRL/STATUS map with a 4-state TX handshake FSM.
// Optional: define UART_OVERRUN_DETECT_EN to drop bytes arriving while RX_DATA is unread.
module uart_register_block #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input logic                  pclk,
    input logic                  prst,
    uart_register_block_if.slave bus
);
    localparam logic [ADDR_W-1:0] A_TX   = ADDR_W'(32'h00);
    localparam logic [ADDR_W-1:0] A_RX   = ADDR_W'(32'h04);
    localparam logic [ADDR_W-1:0] A_CFG  = ADDR_W'(32'h08);
    localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(32'h0C);
    localparam logic [ADDR_W-1:0] A_ST   = ADDR_W'(32'h10);

    typedef enum logic [1:0] {IDLE, LOAD, BUSY, DONE} tx_state_t;

    tx_state_t         r_state, w_next;
    logic [DATA_W-1:0] r_tx_data, r_cfg, r_ctrl, r_rx_data, r_tx_byte, r_rd_data;
    logic              r_rx_full, r_perr, r_overrun, r_done_st;

    logic              w_wr, w_rd, w_rd_rx, w_rd_st, w_clr;
    logic              w_rx_acc, w_rx_ovr, w_rx_load;
    logic              w_tx_valid, w_tx_done, w_load;
    logic [DATA_W-1:0] w_status, w_rd_mux;

    // A simultaneous write suppresses the read entirely, including its clear side effects.
    assign w_wr     = bus.reg_wr_en;
    assign w_rd     = bus.reg_rd_en & ~bus.reg_wr_en;
    assign w_rd_rx  = w_rd & (bus.reg_address == A_RX);
    assign w_rd_st  = w_rd & (bus.reg_address == A_ST);
    assign w_clr    = r_ctrl[2];
    assign w_rx_acc = bus.rx_valid & r_ctrl[1];
`ifdef UART_OVERRUN_DETECT_EN
    assign w_rx_ovr = w_rx_acc & r_rx_full & ~w_rd_rx;
`else
    assign w_rx_ovr = 1'b0;
`endif
    assign w_rx_load = w_rx_acc & ~w_rx_ovr;

    always_comb begin
        w_status      = '0;
        w_status[4:0] = {r_done_st, r_overrun, r_perr, r_rx_full, (r_state != IDLE)};
    end

    always_comb begin
        w_rd_mux = '0;
        case (bus.reg_address)
            A_TX:    w_rd_mux = r_tx_data;
            A_RX:    w_rd_mux = r_rx_data;
            A_CFG:   w_rd_mux = r_cfg;
            A_CTRL:  w_rd_mux = r_ctrl;
            A_ST:    w_rd_mux = w_status;
            default: w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (prst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_tx_valid = 1'b0;
        w_tx_done  = 1'b0;
        w_load     = 1'b0;
        case (r_state)
            IDLE: if (bus.start_tx && r_ctrl[0]) begin
                w_next = LOAD;
                w_load = 1'b1;
            end
            LOAD: begin
                w_tx_valid = 1'b1;
                if (bus.tx_ready) w_next = BUSY;
            end
            BUSY: if (bus.tx_complete) w_next = DONE;
            DONE: begin
                w_tx_done = 1'b1;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            r_tx_data <= '0;
            r_cfg     <= '0;
            r_ctrl    <= '0;
            r_rx_data <= '0;
            r_tx_byte <= '0;
            r_rd_data <= '0;
            r_rx_full <= 1'b0;
            r_perr    <= 1'b0;
            r_overrun <= 1'b0;
            r_done_st <= 1'b0;
        end else begin
            // Self-clear first so a CTRL write in the same cycle takes precedence.
            if (w_clr) r_ctrl[2] <= 1'b0;
            if (w_wr) begin
                case (bus.reg_address)
                    A_TX:    r_tx_data <= bus.data_write_to_reg;
                    A_CFG:   r_cfg     <= bus.data_write_to_reg;
                    A_CTRL:  r_ctrl    <= bus.data_write_to_reg;
                    default: ;
                endcase
            end
            if (w_load)    r_tx_byte <= r_tx_data;
            if (w_rd)      r_rd_data <= w_rd_mux;
            if (w_rx_load) r_rx_data <= bus.rx_byte;

            // Set events beat read-clears so a flag raised during a read is not lost.
            if (w_clr)          r_rx_full <= 1'b0;
            else if (w_rx_load) r_rx_full <= 1'b1;
            else if (w_rd_rx)   r_rx_full <= 1'b0;

            if (w_clr)                             r_perr <= 1'b0;
            else if (w_rx_acc & bus.rx_parity_err) r_perr <= 1'b1;
            else if (w_rd_st)                      r_perr <= 1'b0;

            if (w_clr)         r_overrun <= 1'b0;
            else if (w_rx_ovr) r_overrun <= 1'b1;
            else if (w_rd_st)  r_overrun <= 1'b0;

            if (w_clr)          r_done_st <= 1'b0;
            else if (w_tx_done) r_done_st <= 1'b1;
            else if (w_rd_st)   r_done_st <= 1'b0;
        end
    end

    assign bus.reg_rd_data         = r_rd_data;
    assign bus.rx_data_in          = r_rx_data;
    assign bus.tx_done_signal      = w_tx_done;
    assign bus.rx_done_signal      = r_rx_full;
    assign bus.parity_error_signal = r_perr;
    assign bus.tx_byte             = r_tx_byte;
    assign bus.tx_valid            = w_tx_valid;
    assign bus.cfg_out             = r_cfg;
endmodule
